// File: rtl/fifo_bit_serializer.sv
// fifo_bit_serializer
//   Drain stage for the synchronous FIFO. It is the only reader of the FIFO.
//   Each word is fetched with a single fifo_rd_en pulse and loaded on the
//   following cycle, when the registered read data is valid. The word is then
//   shifted out one bit at a time over a valid/ready handshake. Every output
//   is decoded from registered state, so no input reaches an output through
//   combinational logic.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO registered read data (valid the cycle after rd_en)
//   fifo_rd_en  out  FIFO read strobe, one-cycle pulse per word
//   ser_ready   in   downstream accepts ser_bit this cycle
//   ser_valid   out  ser_bit is valid
//   ser_bit     out  serial data bit
//   ser_last    out  ser_bit is the final bit of the current word
//   busy        out  state is not IDLE
//   word_count  out  words fully transferred since reset (wraps silently)
module fifo_bit_serializer #(
    parameter int DATA_WIDTH = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    input  logic                  ser_ready,
    output logic                  ser_valid,
    output logic                  ser_bit,
    output logic                  ser_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic [BW-1:0]          bit_cnt_q;
    logic [CNT_WIDTH-1:0]   word_count_q;
    logic                   at_last;
    logic                   xfer;

    assign at_last = (bit_cnt_q == LAST_IDX);
    assign xfer    = (state_q == SHIFT) && ser_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD:  state_d = SHIFT;
            SHIFT: begin
                // After the final bit, go straight back to FETCH when more data
                // is waiting so back-to-back words cost only a two-cycle gap.
                if (xfer && at_last) begin
                    state_d = fifo_empty ? IDLE : FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: shift register, bit counter, completed-word counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            word_count_q <= '0;
        end else begin
            if (state_q == LOAD) begin
                shift_q   <= fifo_data;
                bit_cnt_q <= '0;
            end else if (xfer) begin
                if (at_last) begin
                    word_count_q <= word_count_q + CNT_WIDTH'(1);
                end else begin
                    bit_cnt_q <= bit_cnt_q + BW'(1);
                    if (MSB_FIRST) begin
                        shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
                    end
                end
            end
        end
    end

    // Output decode
    always_comb begin
        fifo_rd_en = (state_q == FETCH);
        ser_valid  = (state_q == SHIFT);
        busy       = (state_q != IDLE);
        ser_last   = (state_q == SHIFT) && at_last;
        // Gated so ser_bit reads 0 whenever no bit is being offered.
        ser_bit    = (state_q == SHIFT) &&
                     (MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0]);
        word_count = word_count_q;
    end

endmodule
